// File: rtl/cpu_pkg.sv
// cpu_pkg: shared next-PC select encodings, fetch FSM states and the nop word.
package cpu_pkg;
  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JALR = 2'b10} pc_sel_e;
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, VALID = 2'b10, HALT = 2'b11} fetch_state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic word_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/next_pc.sv
// next_pc: combinational next-PC mux; select 11 falls back to PC+4.
module next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  sel,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] npc
);
  always_comb
    npc = (sel == PC_BRANCH) ? branch_target :
          (sel == PC_JALR)   ? {jump_target[31:1], 1'b0} : pc + 32'd4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: non-prefetching instruction fetch; one request, one held instruction at a time.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  PC_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [31:0] instruction_PC,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        misaligned_fault,
  output logic [31:0] instret
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, npc;
  logic        fetch_done, retire;
  next_pc u_next_pc (
    .pc(pc_q),
    .sel(PC_select),
    .branch_target(branch_target),
    .jump_target(jump_target),
    .npc(npc)
  );
  assign fetch_done        = (state_q == FETCH) && imem_ready;
  assign retire            = (state_q == VALID) && instruction_ready;
  assign imem_request      = state_q == FETCH;
  assign imem_address      = pc_q;
  assign instruction_valid = state_q == VALID;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = FETCH;
    else if (fetch_done) state_d = VALID;
    else if (retire) state_d = word_aligned(npc) ? FETCH : HALT;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q          <= IDLE;
      pc_q             <= RESET_VECTOR;
      instruction      <= NOP;
      instruction_PC   <= RESET_VECTOR;
      misaligned_fault <= 1'b0;
      instret          <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        instruction    <= imem_data;
        instruction_PC <= pc_q;
      end
      if (retire) begin
        pc_q    <= npc;
        instret <= instret + 32'd1;
        if (!word_aligned(npc)) misaligned_fault <= 1'b1;
      end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 PC_select  input  2  next-PC source for the held instruction: 00 PC+4, 01 branch_target, 10 jump_target (jalr).
REQ-005 branch_target  input  32  PC+imm from the datapath (branch/jal).
REQ-006 jump_target  input  32  ALU result for jalr.
REQ-007 imem_request  output  1  instruction memory read request.
REQ-008 imem_address  output  32  word address of the request, equal to PC.
REQ-009 imem_ready  input  1  memory returns imem_data valid this cycle.
REQ-010 imem_data  input  32  instruction word from memory.
REQ-011 instruction  output  32  registered instruction word to the decoder/controller.
REQ-012 instruction_PC  output  32  PC of the held instruction.
REQ-013 instruction_valid  output  1  instruction/instruction_PC valid.
REQ-014 instruction_ready  input  1  downstream retires the held instruction; PC_select and targets valid this cycle.
REQ-015 misaligned_fault  output  1  sticky: next PC not 4-byte aligned.
REQ-016 instret  output  32  retired-instruction counter.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, VALID, HALT.
REQ-018 IDLE SHALL advance to FETCH on the first clock edge after reset_n deasserts.
REQ-019 In FETCH, imem_request SHALL be 1 and imem_address SHALL equal PC; the request is held until imem_ready.
REQ-020 In FETCH with imem_ready=1, imem_data SHALL be latched into instruction, PC into instruction_PC, and the state SHALL move to VALID; zero-wait memory (imem_ready in the first FETCH cycle) gives instruction_valid one cycle after request assertion.
REQ-021 In VALID, instruction_valid SHALL be 1, and instruction and instruction_PC SHALL hold stable until instruction_ready.
REQ-022 In VALID with instruction_ready=1, next PC SHALL be computed: 00 -> PC+4 (mod 2^32, wraps), 01 -> branch_target, 10 -> jump_target with bit 0 cleared, 11 -> PC+4.
REQ-023 On retirement, instret SHALL increment by 1 (wraps at 2^32).
REQ-024 On retirement with an aligned next PC (bits [1:0] = 00), PC SHALL load the next PC and the state SHALL return to FETCH; the next request asserts the following cycle.
REQ-025 On retirement with next PC[1:0] != 00, misaligned_fault SHALL set, PC SHALL load the faulting value, and the state SHALL move to HALT.
REQ-026 HALT SHALL be exited only by reset; in HALT, imem_request=0 and instruction_valid=0.
REQ-027 imem_ready outside FETCH and instruction_ready outside VALID SHALL be ignored.
REQ-028 imem_request and instruction_valid SHALL never be 1 in the same cycle (no prefetch).

Reset
REQ-029 While reset_n=0: state=IDLE, PC=RESET_VECTOR, instruction=32'h0000_0013 (nop), instruction_PC=RESET_VECTOR, instruction_valid=0, imem_request=0, misaligned_fault=0, instret=0.
REQ-030 Reset asserted mid-fetch or mid-hold SHALL abort immediately (asynchronously); a late imem_ready after reset SHALL be ignored.

Structure
REQ-031 PC_select encodings (PC_PLUS4, PC_BRANCH, PC_JALR), the FSM state encoding, and the nop constant SHALL live in the shared cpu package.
REQ-032 The next-PC adder/mux SHALL be a combinational sub-module named next_pc.

Verification
REQ-033 Reset release, imem_ready tied 1 -> request at 0x0, then instruction_valid with instruction_PC=0x0 one cycle later.
REQ-034 PC=0x10, PC_select=01, branch_target=0x40, instruction_ready=1 -> imem_address=0x40 next cycle, instret +1.
REQ-035 PC_select=10, jump_target=0x85 -> next PC 0x84; jump_target=0x86 -> misaligned_fault=1, HALT, no further requests.
REQ-036 imem_ready delayed 3 cycles -> imem_request and imem_address held 4 cycles; instruction_valid asserts exactly once.
REQ-037 PC=0xFFFF_FFFC, PC_select=00 -> next fetch at 0x0000_0000; instret preset near 0xFFFF_FFFF wraps to 0.
REQ-038 reset_n pulsed low during FETCH -> all outputs reach reset values without a clock edge; fetch restarts at RESET_VECTOR.
